spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Rate decoder that reads the spike trains produced by the LIF neuron network and turns them back into per-channel spike counts. Each channel counts spikes over a programmable window. At window end, the block latches all counts into an output register and presents them over a valid/ready handshake. It sits between the network's spike outputs and the readout/monitoring logic on the tile.

## Interface
Parameters:
- NUM_CH, 4, number of spike channels (neuron 1, 2, 3, final).
- CNT_W, 8, width of each per-channel counter and result field.
- WIN_W, 8, width of the window-length input and the window counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- spike_in  in  NUM_CH  spike lines from the network; bit i = channel i.
- window_len  in  WIN_W  window length in cycles; 0 means 2^WIN_W.
- start  in  1  begins a window when in IDLE; ignored otherwise.
- stop  in  1  aborts counting; returns to IDLE.
- cont  in  1  continuous mode: restart a new window immediately at window end.
- busy  out  1  high in COUNT.
- rate_valid  out  1  result register holds an unconsumed result.
- rate_ready  in  1  consumer accepts the result when high together with rate_valid.
- rate_data  out  NUM_CH*CNT_W  channel i count at [i*CNT_W +: CNT_W].
- rate_sat  out  NUM_CH  channel i counter saturated during that window.
- overrun  out  1  sticky: a result was overwritten before it was consumed.

## Operation
- States: IDLE, COUNT.
- IDLE with start=1 goes to COUNT. The block loads the window counter from window_len and clears the channel counters and sat bits.
- COUNT: each cycle, every channel adds its increment; the window counter decrements.
- The increment is 1 if the channel's spike condition holds, else 0.
- Counters saturate at 2^CNT_W-1, and the channel's sat bit is set when that happens.
- Last window cycle: rate_data is loaded with the count plus that cycle's increment, and rate_sat with the sat bits; rate_valid is set.
  - Same cycle: if cont=1, the counters clear, window_len is reloaded and the block stays in COUNT, so there is no gap cycle. Otherwise it goes to IDLE.
- stop=1 in COUNT: go to IDLE next cycle. Partial counts are discarded, no result is produced, and the output register is untouched. If stop and the last window cycle coincide, stop wins and no result is loaded.
- start during COUNT is ignored.
- Handshake: rate_valid=1 and rate_ready=1 consumes the result, and rate_valid clears next cycle.
  - A new result loading in the same cycle as a consume leaves rate_valid=1 and does not set overrun.
  - A new result loading while rate_valid=1 and rate_ready=0 overwrites the data and sets overrun.
  - rate_data and rate_sat are stable while rate_valid=1 until consumed or overwritten.
- overrun is cleared by reset or by an accepted start.
- Reset (any state): state IDLE; busy=0, rate_valid=0, rate_data=0, rate_sat=0, overrun=0; counters and edge registers are 0.

## Timing
- The cycle in which start is sampled is not counted. The window covers the following N cycles, where N = window_len, or 2^WIN_W when window_len is 0.
- busy rises 1 cycle after start and stays high for exactly N cycles in single mode.
- rate_valid rises on the cycle after the N-th counted cycle; latency from start is N+1 cycles.
- In continuous mode, windows are back-to-back, each exactly N cycles.
- spike_in is sampled directly; the network's spike outputs are synchronous to clk, so no synchroniser is needed.

## Configuration
- RATE_DEC_EDGE_EN defined: the spike condition is a rising edge, spike_in[i]=1 while the previous sample was 0.
  - The previous-sample register is updated every cycle in every state.
  - A line held high across a window boundary is counted once.
- RATE_DEC_EDGE_EN undefined: the spike condition is spike_in[i]=1, so every high cycle counts and there are no previous-sample registers.

## Structure
- Package rate_dec_pkg holds:
  - the state enum (IDLE, COUNT);
  - default localparams for NUM_CH, CNT_W, WIN_W;
  - the all-ones saturation constant function.
- Sub-module spike_channel_counter, instantiated NUM_CH times, holds:
  - optional edge detect;
  - saturating counter with clear;
  - sat bit.
- The top level holds the FSM, window counter, result register and handshake.

## Test plan
- window_len=10, single mode, channel 0 pulsed 1 cycle every 3 cycles starting at the first window cycle: rate_valid rises 11 cycles after start, rate_data[7:0]=4, other channels 0, busy=0 afterwards.
- window_len=0, channel 1 held high, edge mode undefined: count saturates to 255, rate_sat[1]=1. Same run with RATE_DEC_EDGE_EN defined: count=1, rate_sat[1]=0.
- cont=1, window_len=4, rate_ready=0, channel 2 held low: second result sets overrun=1, rate_valid stays 1. Then assert rate_ready in the same cycle as the third load: overrun is unchanged and rate_valid stays 1.
- stop asserted on cycle 3 of an 8-cycle window: IDLE next cycle, rate_valid stays 0, rate_data unchanged from its previous value.
- reset asserted mid-COUNT with rate_valid=1 and overrun=1: the next cycle shows all outputs 0 and state IDLE. start then works normally.
- start pulsed again during COUNT: ignored, and the window ends at its original cycle.

Source files
------------

// File: rtl/rate_dec_pkg.sv
// Shared types and defaults for the spike rate decoder.
package rate_dec_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned WIN_W_DEF  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // All-ones value of width w, used as the saturation ceiling.
  function automatic logic [31:0] all_ones(input int unsigned w);
    all_ones = (w >= 32) ? 32'hffff_ffff : ((32'h1 << w) - 32'h1);
  endfunction

endpackage

// File: rtl/spike_channel_counter.sv
// One channel: optional rising-edge detect, saturating counter with clear, sat flag.
// RATE_DEC_EDGE_EN selects edge counting instead of level counting.
module spike_channel_counter
  import rate_dec_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_next_c,
  output logic             sat_next_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(all_ones(CNT_W));

  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             inc;

`ifdef RATE_DEC_EDGE_EN
  logic prev_q;

  // Previous sample tracks the line every cycle, independent of the window.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= spike;
  end

  assign inc = spike & ~prev_q;
`else
  assign inc = spike;
`endif

  // Count including this cycle's increment; the top latches this at window end.
  always_comb begin
    cnt_next_c = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) cnt_next_c = cnt_q + CNT_W'(1);
    sat_next_c = sat_q | (cnt_next_c == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (en) begin
      cnt_q <= cnt_next_c;
      sat_q <= sat_next_c;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed per-channel spike rate decoder with a valid/ready result register.
// Define RATE_DEC_EDGE_EN to count rising edges rather than high cycles.
module spike_rate_decoder
  import rate_dec_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]        window_len,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cont,
  output logic                    busy,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic [NUM_CH*CNT_W-1:0] rate_data,
  output logic [NUM_CH-1:0]       rate_sat,
  output logic                    overrun
);

  state_t state_q, state_d;

  logic [WIN_W-1:0]        win_q;
  logic                    last;
  logic                    accept;
  logic                    load;
  logic                    clr;
  logic                    en;
  logic [NUM_CH*CNT_W-1:0] cnt_next;
  logic [NUM_CH-1:0]       sat_next;

  // A loaded 0 wraps through all ones, giving the full 2^WIN_W window.
  assign last = (win_q == WIN_W'(1));
  assign en   = (state_q == COUNT);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          clr     = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (last) begin
          load = 1'b1;
          if (cont) clr = 1'b1;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   win_q <= '0;
    else if (accept || clr)      win_q <= window_len;
    else if (state_q == COUNT)   win_q <= win_q - WIN_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_channel_counter #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .spike      (spike_in[i]),
      .en         (en),
      .clr        (clr),
      .cnt_next_c (cnt_next[i*CNT_W +: CNT_W]),
      .sat_next_c (sat_next[i])
    );
  end

  // Result register; a load in the same cycle as a consume is not an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_valid <= 1'b0;
      rate_data  <= '0;
      rate_sat   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rate_data <= cnt_next;
        rate_sat  <= sat_next;
      end
      rate_valid <= load | (rate_valid & ~rate_ready);
      if (accept)                                 overrun <= 1'b0;
      else if (load && rate_valid && !rate_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: directed scenarios plus random traffic.
module tb_spike_rate_decoder;

  localparam int NC   = 4;
  localparam int CW   = 8;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] spike_in;
  logic [7:0]    window_len;
  logic          start, stop, cont, rate_ready;
  logic          busy, rate_valid, overrun;
  logic [NC*CW-1:0] rate_data;
  logic [NC-1:0]    rate_sat;

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .window_len(window_len),
    .start(start), .stop(stop), .cont(cont), .busy(busy),
    .rate_valid(rate_valid), .rate_ready(rate_ready), .rate_data(rate_data),
    .rate_sat(rate_sat), .overrun(overrun)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } res_t;

  res_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: window bookkeeping in plain integers.
  bit          m_active = 0;
  int          m_left   = 0;
  int          tot[NC];
  bit          prev[NC];
  bit          m_valid  = 0;
  bit          m_ovr    = 0;
  logic [31:0] m_data   = '0;
  logic [3:0]  m_sat    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   consume, ld, edge_mode;
    res_t r, dropped;
`ifdef RATE_DEC_EDGE_EN
    edge_mode = 1;
`else
    edge_mode = 0;
`endif
    ld = 0;
    if (reset) begin
      m_active = 0; m_left = 0; m_valid = 0; m_ovr = 0; m_data = '0; m_sat = '0;
      for (int i = 0; i < NC; i++) tot[i] = 0;
      q.delete();
    end else begin
      consume = m_valid && rate_ready;
      if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_left   = (window_len == 0) ? 256 : int'(window_len);
          for (int i = 0; i < NC; i++) tot[i] = 0;
          m_ovr = 0;
        end
      end else begin
        for (int i = 0; i < NC; i++)
          if (spike_in[i] && !(edge_mode && prev[i])) tot[i]++;
        m_left--;
        if (stop) begin
          m_active = 0;
        end else if (m_left == 0) begin
          for (int i = 0; i < NC; i++) begin
            r.d[i*CW +: CW] = CW'((tot[i] >= MAXV) ? MAXV : tot[i]);
            r.s[i]          = (tot[i] >= MAXV);
          end
          ld = 1;
          if (cont) begin
            m_left = (window_len == 0) ? 256 : int'(window_len);
            for (int i = 0; i < NC; i++) tot[i] = 0;
          end else begin
            m_active = 0;
          end
        end
      end
      if (ld) begin
        if (m_valid && !consume) begin
          m_ovr = 1;
          if (q.size() > 0) dropped = q.pop_back();
        end
        q.push_back(r);
        m_data  = r.d;
        m_sat   = r.s;
        m_valid = 1;
      end else begin
        m_valid = m_valid && !consume;
      end
    end
    for (int i = 0; i < NC; i++) prev[i] = reset ? 1'b0 : spike_in[i];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare visible outputs each cycle and pop on every handshake.
  initial begin
    res_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(m_active));
      chk("rate_valid", 32'(rate_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("rate_data", rate_data, m_data);
      chk("rate_sat", 32'(rate_sat), 32'(m_sat));
      if (rate_valid && rate_ready) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop: DUT presented a result, expected none at %0t", $time);
        end else begin
          r = q.pop_front();
          chk("pop_data", rate_data, r.d);
          chk("pop_sat", 32'(rate_sat), 32'(r.s));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rate_ready = 1;
    repeat (2) cyc();
    rate_ready = 0;
  endtask

  initial begin
    logic [31:0] saved;
    reset = 1; spike_in = '0; window_len = '0; start = 0; stop = 0; cont = 0; rate_ready = 0;
    repeat (2) cyc();
    reset = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rate_valid), 32'd0);
    chk("rst_data", rate_data, 32'd0);

    // Window of 10, channel 0 pulsed every 3rd cycle from the first window cycle.
    window_len = 8'd10; start = 1; cyc(); start = 0;
    for (int i = 0; i < 10; i++) begin
      spike_in = {3'b000, (i % 3 == 0)};
      cyc();
      if (i == 8) chk("lat_not_yet", 32'(rate_valid), 32'd0);
    end
    spike_in = '0;
    chk("lat_valid", 32'(rate_valid), 32'd1);
    chk("w10_data", rate_data, 32'h0000_0004);
    chk("w10_busy", 32'(busy), 32'd0);
    drain();

    // Full 256-cycle window with channel 1 held high.
    window_len = 8'd0; start = 1; cyc(); start = 0;
    spike_in = 4'b0010;
    repeat (256) cyc();
    spike_in = '0;
`ifdef RATE_DEC_EDGE_EN
    chk("w256_cnt", 32'(rate_data[15:8]), 32'd1);
    chk("w256_sat", 32'(rate_sat[1]), 32'd0);
`else
    chk("w256_cnt", 32'(rate_data[15:8]), 32'd255);
    chk("w256_sat", 32'(rate_sat[1]), 32'd1);
`endif
    drain();

    // Continuous windows of 4 with no consumer, then consume on the third load.
    window_len = 8'd4; cont = 1; spike_in = 4'b1011; start = 1; cyc(); start = 0;
    repeat (8) cyc();
    chk("cont_ovr", 32'(overrun), 32'd1);
    chk("cont_valid", 32'(rate_valid), 32'd1);
    repeat (3) cyc();
    rate_ready = 1; cyc(); rate_ready = 0;
    chk("cont_ovr_hold", 32'(overrun), 32'd1);
    chk("cont_valid_hold", 32'(rate_valid), 32'd1);
    cont = 0;
    repeat (6) cyc();
    spike_in = '0;
    drain();

    // Stop on the third cycle of an 8-cycle window.
    saved = rate_data;
    window_len = 8'd8; start = 1; cyc(); start = 0;
    spike_in = 4'b1111; cyc(); cyc();
    stop = 1; cyc(); stop = 0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_valid", 32'(rate_valid), 32'd0);
    chk("stop_data", rate_data, saved);
    spike_in = '0;
    repeat (10) cyc();
    chk("stop_no_result", 32'(rate_valid), 32'd0);

    // Reset in the middle of a continuous run with a pending, overrun result.
    window_len = 8'd2; cont = 1; spike_in = 4'b0101; start = 1; cyc(); start = 0;
    repeat (5) cyc();
    chk("pre_rst_ovr", 32'(overrun), 32'd1);
    reset = 1; cyc(); reset = 0; cont = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rate_valid), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_data", rate_data, 32'd0);
    window_len = 8'd3; start = 1; cyc(); start = 0;
    repeat (3) cyc();
    chk("post_rst_valid", 32'(rate_valid), 32'd1);
    spike_in = '0;
    drain();

    // A second start during COUNT must not stretch the window.
    window_len = 8'd6; start = 1; cyc(); start = 0;
    cyc(); start = 1; cyc(); start = 0;
    repeat (3) cyc();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_early", 32'(rate_valid), 32'd0);
    cyc();
    chk("restart_end", 32'(rate_valid), 32'd1);
    chk("restart_idle", 32'(busy), 32'd0);
    drain();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      spike_in   = NC'($urandom);
      rate_ready = ($urandom % 2) == 0;
      start      = ($urandom % 6) == 0;
      stop       = ($urandom % 40) == 0;
      cont       = ($urandom % 4) == 0;
      window_len = (($urandom % 32) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      reset      = ($urandom % 700) == 0;
      cyc();
    end
    reset = 0; start = 0; stop = 0; cont = 0; spike_in = '0;
    repeat (300) cyc();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
